// File: rtl/rr_arb_mux_if.sv
// rr_arb_mux_if: handshake bundle between N producers, the arbitrating mux
// and its single consumer. The mux side takes the slave modport.
interface rr_arb_mux_if #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    parameter int SELW     = $clog2(CHANNELS)
);
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_ready;
    logic                      out_valid;
    logic [WIDTH-1:0]          out_data;
    logic [SELW-1:0]           out_sel;
    logic                      out_ready;

    // mux side: consumes producer offers, drives the output register
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );

    // environment side: producers plus the downstream consumer
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );
endinterface

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-channel, W-bit registered multiplexer with built-in
// round-robin / fixed-priority arbitration and a one-entry output register.
// The round-robin pointer is kept below CHANNELS at all times, so
// non-power-of-two channel counts never see an out-of-range index.
module rr_arb_mux #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mode,
    rr_arb_mux_if.slave bus
);
    localparam int SELW = $clog2(CHANNELS);
    localparam int CW   = SELW + 1;
    localparam logic [SELW-1:0] LAST = SELW'(CHANNELS - 1);

    logic [SELW-1:0]     ptr;
    logic                load_en;
    logic                gnt_found;
    logic [SELW-1:0]     gnt_idx;
    logic [WIDTH-1:0]    gnt_data;
    logic [CW-1:0]       cand;
    logic [CHANNELS-1:0] ready_c;
    logic                xfer;
    logic                out_valid_q;
    logic [WIDTH-1:0]    out_data_q;
    logic [SELW-1:0]     out_sel_q;

    assign load_en = !out_valid_q || bus.out_ready;

    // Find the first requester scanning upward from ptr (round-robin) or 0 (fixed)
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            // one extra bit keeps base+k from overflowing before the wrap
            cand = {1'b0, (mode ? {SELW{1'b0}} : ptr)} + CW'(k);
            if (cand >= CW'(CHANNELS)) begin
                cand = cand - CW'(CHANNELS);
            end
            if (!gnt_found && bus.in_valid[cand[SELW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[SELW-1:0];
            end
        end
    end

    // Select the granted channel's word with constant slices only
    always_comb begin
        gnt_data = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (gnt_idx == SELW'(c)) begin
                gnt_data = bus.in_data[c*WIDTH +: WIDTH];
            end
        end
    end

    // One-hot accept, suppressed under backpressure and during reset
    always_comb begin
        ready_c = '0;
        if (!reset && load_en && gnt_found) begin
            ready_c[gnt_idx] = 1'b1;
        end
    end

    assign xfer = |ready_c;

    // Output register and round-robin pointer; load wins over drain so a
    // consume and a new load on the same edge leave no bubble
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr         <= '0;
        end else if (xfer) begin
            out_valid_q <= 1'b1;
            out_data_q  <= gnt_data;
            out_sel_q   <= gnt_idx;
            if (!mode) begin
                ptr <= (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
            end
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;
endmodule

// File: tb/tb_rr_arb_mux.sv
// tb_rr_arb_mux: directed checks on a 4-channel/32-bit instance plus a
// 3-channel/8-bit instance exercised with directed wrap and a scoreboarded
// random run.
module tb_rr_arb_mux;
    localparam logic [31:0] A0 = 32'h0000_00A0;
    localparam logic [31:0] B1 = 32'h0000_00B1;
    localparam logic [31:0] C2 = 32'h0000_00C2;
    localparam logic [31:0] D3 = 32'h0000_00D3;
    localparam logic [31:0] E2 = 32'h0000_00E2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, mode, reset3, mode3;
    int   errors = 0;
    int   checks = 0;

    rr_arb_mux_if #(.WIDTH(32), .CHANNELS(4)) bus4 ();
    rr_arb_mux_if #(.WIDTH(8),  .CHANNELS(3)) bus3 ();

    rr_arb_mux #(.WIDTH(32), .CHANNELS(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .mode  (mode),
        .bus   (bus4)
    );

    rr_arb_mux #(.WIDTH(8), .CHANNELS(3)) dut3 (
        .clk   (clk),
        .reset (reset3),
        .mode  (mode3),
        .bus   (bus3)
    );

    task automatic test_reset();
        reset = 1'b1;
        mode = 1'b0;
        bus4.in_valid = 4'b1111;
        bus4.in_data = {D3, C2, B1, A0};
        bus4.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (bus4.in_ready !== 4'b0000) begin
                errors++;
                $display("FAIL reset_in_ready: got %b expected 0000", bus4.in_ready);
            end
            @(posedge clk); #1;
            checks++;
            if (bus4.out_valid !== 1'b0 || bus4.out_data !== 32'h0 || bus4.out_sel !== 2'd0) begin
                errors++;
                $display("FAIL reset_outputs: got valid=%b data=%h sel=%0d expected 0/0/0",
                         bus4.out_valid, bus4.out_data, bus4.out_sel);
            end
        end
        reset = 1'b0;
        #1;
        checks++;
        if (bus4.in_ready !== 4'b0001) begin
            errors++;
            $display("FAIL reset_first_grant: got %b expected 0001", bus4.in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (bus4.out_valid !== 1'b1 || bus4.out_sel !== 2'd0 || bus4.out_data !== A0) begin
            errors++;
            $display("FAIL reset_first_word: got valid=%b sel=%0d data=%h expected 1/0/%h",
                     bus4.out_valid, bus4.out_sel, bus4.out_data, A0);
        end
    endtask

    task automatic test_rr_rotation();
        int          exp_sel [5] = '{0, 1, 2, 3, 0};
        logic [31:0] words   [4] = '{A0, B1, C2, D3};
        logic [3:0]  exp_rdy;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        mode = 1'b0;
        bus4.in_valid = 4'b1111;
        bus4.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp_rdy = '0;
            exp_rdy[exp_sel[i]] = 1'b1;
            #1;
            checks++;
            if (bus4.in_ready !== exp_rdy) begin
                errors++;
                $display("FAIL rr_ready[%0d]: got %b expected %b", i, bus4.in_ready, exp_rdy);
            end
            @(posedge clk); #1;
            checks++;
            if (bus4.out_valid !== 1'b1 || bus4.out_sel !== 2'(exp_sel[i]) || bus4.out_data !== words[exp_sel[i]]) begin
                errors++;
                $display("FAIL rr_word[%0d]: got valid=%b sel=%0d data=%h expected 1/%0d/%h",
                         i, bus4.out_valid, bus4.out_sel, bus4.out_data, exp_sel[i], words[exp_sel[i]]);
            end
        end
    endtask

    task automatic test_fixed_skip();
        int         exp_sel [4] = '{1, 3, 1, 3};
        logic [3:0] exp_rdy;
        mode = 1'b1;
        bus4.in_valid = 4'b1111;
        #1;
        checks++;
        if (bus4.in_ready !== 4'b0001) begin
            errors++;
            $display("FAIL fixed_all: got %b expected 0001", bus4.in_ready);
        end
        @(posedge clk); #1;
        bus4.in_valid = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (bus4.in_ready !== 4'b0010) begin
                errors++;
                $display("FAIL fixed_ready[%0d]: got %b expected 0010", i, bus4.in_ready);
            end
            @(posedge clk); #1;
            checks++;
            if (bus4.out_sel !== 2'd1 || bus4.out_data !== B1) begin
                errors++;
                $display("FAIL fixed_word[%0d]: got sel=%0d data=%h expected 1/%h",
                         i, bus4.out_sel, bus4.out_data, B1);
            end
        end
        // pointer was left at 1 by rotation and untouched by fixed mode
        mode = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_rdy = '0;
            exp_rdy[exp_sel[i]] = 1'b1;
            #1;
            checks++;
            if (bus4.in_ready !== exp_rdy) begin
                errors++;
                $display("FAIL skip_ready[%0d]: got %b expected %b", i, bus4.in_ready, exp_rdy);
            end
            @(posedge clk); #1;
            checks++;
            if (bus4.out_sel !== 2'(exp_sel[i])) begin
                errors++;
                $display("FAIL skip_sel[%0d]: got %0d expected %0d", i, bus4.out_sel, exp_sel[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        bus4.in_valid = 4'b0100;
        bus4.out_ready = 1'b1;
        #1;
        checks++;
        if (bus4.in_ready !== 4'b0100) begin
            errors++;
            $display("FAIL bp_load_ready: got %b expected 0100", bus4.in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (bus4.out_data !== C2 || bus4.out_sel !== 2'd2) begin
            errors++;
            $display("FAIL bp_load_word: got sel=%0d data=%h expected 2/%h", bus4.out_sel, bus4.out_data, C2);
        end
        bus4.out_ready = 1'b0;
        bus4.in_data = {D3, E2, B1, A0};
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (bus4.in_ready !== 4'b0000) begin
                errors++;
                $display("FAIL bp_stall_ready[%0d]: got %b expected 0000", i, bus4.in_ready);
            end
            @(posedge clk); #1;
            checks++;
            if (bus4.out_valid !== 1'b1 || bus4.out_data !== C2) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got valid=%b data=%h expected 1/%h",
                         i, bus4.out_valid, bus4.out_data, C2);
            end
        end
        bus4.out_ready = 1'b1;
        #1;
        checks++;
        if (bus4.in_ready !== 4'b0100) begin
            errors++;
            $display("FAIL bp_release_ready: got %b expected 0100", bus4.in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (bus4.out_valid !== 1'b1 || bus4.out_data !== E2 || bus4.out_sel !== 2'd2) begin
            errors++;
            $display("FAIL bp_no_bubble: got valid=%b sel=%0d data=%h expected 1/2/%h",
                     bus4.out_valid, bus4.out_sel, bus4.out_data, E2);
        end
    endtask

    task automatic test_drain();
        bus4.in_valid = 4'b0000;
        bus4.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (bus4.in_ready !== 4'b0000) begin
                errors++;
                $display("FAIL drain_ready[%0d]: got %b expected 0000", i, bus4.in_ready);
            end
            @(posedge clk); #1;
            checks++;
            if (bus4.out_valid !== 1'b0 || bus4.out_sel !== 2'd2 || bus4.out_data !== E2) begin
                errors++;
                $display("FAIL drain_idle[%0d]: got valid=%b sel=%0d data=%h expected 0/2/%h",
                         i, bus4.out_valid, bus4.out_sel, bus4.out_data, E2);
            end
        end
    endtask

    task automatic test_reset_discard();
        // pointer sits at 3: scan 3 then wraps to 0
        bus4.in_valid = 4'b0001;
        bus4.out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus4.out_valid !== 1'b1 || bus4.out_data !== A0 || bus4.out_sel !== 2'd0) begin
            errors++;
            $display("FAIL wrap_word: got valid=%b sel=%0d data=%h expected 1/0/%h",
                     bus4.out_valid, bus4.out_sel, bus4.out_data, A0);
        end
        bus4.out_ready = 1'b0;
        bus4.in_valid = 4'b0010;
        reset = 1'b1;
        #1;
        checks++;
        if (bus4.in_ready !== 4'b0000) begin
            errors++;
            $display("FAIL discard_ready: got %b expected 0000", bus4.in_ready);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        checks++;
        if (bus4.out_valid !== 1'b0 || bus4.out_data !== 32'h0 || bus4.out_sel !== 2'd0) begin
            errors++;
            $display("FAIL discard_outputs: got valid=%b sel=%0d data=%h expected 0/0/0",
                     bus4.out_valid, bus4.out_sel, bus4.out_data);
        end
        bus4.in_valid = 4'b0000;
    endtask

    task automatic test_odd_channels();
        logic [7:0] pdata [3];
        logic [2:0] pend;
        logic [2:0] exp3;
        logic [5:0] seq;
        logic [9:0] sb_q [$];
        logic [9:0] front;
        logic       m_valid;
        logic       load;
        logic       found;
        int         m_ptr;
        int         g;
        int         cc;

        reset3 = 1'b1;
        mode3 = 1'b0;
        bus3.out_ready = 1'b1;
        bus3.in_valid = 3'b000;
        bus3.in_data = {8'h32, 8'h21, 8'h10};
        @(posedge clk); #1;
        reset3 = 1'b0;
        bus3.in_valid = 3'b100;
        #1;
        checks++;
        if (bus3.in_ready !== 3'b100) begin
            errors++;
            $display("FAIL odd_ch2_ready: got %b expected 100", bus3.in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (bus3.out_sel !== 2'd2 || bus3.out_data !== 8'h32) begin
            errors++;
            $display("FAIL odd_ch2_word: got sel=%0d data=%h expected 2/32", bus3.out_sel, bus3.out_data);
        end
        bus3.in_valid = 3'b111;
        #1;
        checks++;
        if (bus3.in_ready !== 3'b001) begin
            errors++;
            $display("FAIL odd_wrap_ready: got %b expected 001", bus3.in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (bus3.out_sel !== 2'd0 || bus3.out_data !== 8'h10) begin
            errors++;
            $display("FAIL odd_wrap_word: got sel=%0d data=%h expected 0/10", bus3.out_sel, bus3.out_data);
        end

        reset3 = 1'b1;
        bus3.in_valid = 3'b000;
        @(posedge clk); #1;
        reset3 = 1'b0;
        pend = '0;
        seq = '0;
        m_valid = 1'b0;
        m_ptr = 0;
        for (int i = 0; i < 3; i++) pdata[i] = '0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            for (int c = 0; c < 3; c++) begin
                if (!pend[c] && $urandom_range(0, 2) != 0) begin
                    pend[c] = 1'b1;
                    pdata[c] = {2'(c), seq};
                    seq = seq + 6'd1;
                end
            end
            bus3.in_valid = pend;
            bus3.in_data = {pdata[2], pdata[1], pdata[0]};
            mode3 = ($urandom_range(0, 3) == 0);
            bus3.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            load = !m_valid || bus3.out_ready;
            found = 1'b0;
            g = 0;
            for (int k = 0; k < 3; k++) begin
                cc = ((mode3 ? 0 : m_ptr) + k) % 3;
                if (!found && pend[cc]) begin
                    found = 1'b1;
                    g = cc;
                end
            end
            exp3 = '0;
            if (found && load) exp3[g] = 1'b1;
            checks++;
            if (bus3.in_ready !== exp3) begin
                errors++;
                $display("FAIL rand_ready[%0d]: got %b expected %b", cyc, bus3.in_ready, exp3);
            end
            checks++;
            if (bus3.out_sel === 2'd3) begin
                errors++;
                $display("FAIL rand_sel_range[%0d]: got 3 expected <3", cyc);
            end
            if (m_valid && bus3.out_ready) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_sb_empty[%0d]: got word %h expected none", cyc, bus3.out_data);
                end else begin
                    front = sb_q.pop_front();
                    if ({bus3.out_sel, bus3.out_data} !== front) begin
                        errors++;
                        $display("FAIL rand_sb_word[%0d]: got sel=%0d data=%h expected sel=%0d data=%h",
                                 cyc, bus3.out_sel, bus3.out_data, front[9:8], front[7:0]);
                    end
                end
            end
            if (exp3 != 3'b000) begin
                sb_q.push_back({2'(g), pdata[g]});
                pend[g] = 1'b0;
                m_valid = 1'b1;
                if (!mode3) m_ptr = (g + 1) % 3;
            end else if (m_valid && bus3.out_ready) begin
                m_valid = 1'b0;
            end
            @(posedge clk); #1;
            checks++;
            if (bus3.out_valid !== m_valid) begin
                errors++;
                $display("FAIL rand_out_valid[%0d]: got %b expected %b", cyc, bus3.out_valid, m_valid);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        mode = 1'b0;
        reset3 = 1'b1;
        mode3 = 1'b0;
        bus4.in_valid = '0;
        bus4.in_data = '0;
        bus4.out_ready = 1'b1;
        bus3.in_valid = '0;
        bus3.in_data = '0;
        bus3.out_ready = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_rr_rotation();
        test_fixed_skip();
        test_backpressure();
        test_drain();
        test_reset_discard();
        test_odd_channels();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
